// File: rtl/ram_arbiter.sv
// ram_arbiter
//
// Shares one single-port 32x8 RAM (registered address, unregistered q) between
// two requesters. Commands are serialized through a four-state FSM
// (IDLE -> ISSUE -> WAIT -> DONE). Ties are broken round-robin. Every output
// comes straight from a flop.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and keeps
// them stable until it sees ackN. It must drop reqN during the ackN cycle;
// a reqN still high in the next IDLE cycle is taken as a new command.
//
// Ports
//   CLOCK_50          system clock, rising edge
//   resetn            asynchronous active-low reset
//   req0/req1         request, held until ack
//   we0/we1           1 = write, 0 = read
//   addr0/addr1       word address
//   wdata0/wdata1     write data
//   ack0/ack1         one-cycle completion pulse
//   rdata0/rdata1     read data, valid with ack, held until the next read
//   ram_address       RAM address
//   ram_data          RAM write data
//   ram_wren          RAM write enable (high only in ISSUE)
//   ram_q             RAM read data
//   owner             00 idle, 01 requester 0, 10 requester 1
//   dbg_state         current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)
module ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [1:0]        owner,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_last;   // last granted requester: 0 or 1
  logic                r_we;     // latched command type
  logic                r_ack0;
  logic                r_ack1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic [ADDR_W-1:0]   r_ram_address;
  logic [DATA_W-1:0]   r_ram_data;
  logic                r_ram_wren;
  logic [1:0]          r_owner;

  state_t              w_state;
  logic                w_last;
  logic                w_we;
  logic                w_ack0;
  logic                w_ack1;
  logic [DATA_W-1:0]   w_rdata0;
  logic [DATA_W-1:0]   w_rdata1;
  logic [ADDR_W-1:0]   w_ram_address;
  logic [DATA_W-1:0]   w_ram_data;
  logic                w_ram_wren;
  logic [1:0]          w_owner;
  logic                w_pick1;

  // Requester 1 wins when it is alone, or on a tie when requester 0 went last.
  assign w_pick1 = req1 & (~req0 | ~r_last);

  always_comb begin
    w_state       = r_state;
    w_last        = r_last;
    w_we          = r_we;
    w_ack0        = 1'b0;
    w_ack1        = 1'b0;
    w_rdata0      = r_rdata0;
    w_rdata1      = r_rdata1;
    w_ram_address = r_ram_address;
    w_ram_data    = r_ram_data;
    w_ram_wren    = 1'b0;
    w_owner       = r_owner;
    case (r_state)
      S_IDLE: begin
        if (req0 | req1) begin
          // The RAM address/data registers double as the latched command.
          w_state       = S_ISSUE;
          w_last        = w_pick1;
          w_owner       = w_pick1 ? 2'b10 : 2'b01;
          w_we          = w_pick1 ? we1 : we0;
          w_ram_wren    = w_pick1 ? we1 : we0;
          w_ram_address = w_pick1 ? addr1 : addr0;
          w_ram_data    = w_pick1 ? wdata1 : wdata0;
        end
      end
      S_ISSUE: begin
        // RAM registers the address (and performs any write) at this edge.
        w_state = S_WAIT;
      end
      S_WAIT: begin
        // q now reflects the address clocked in at the end of ISSUE.
        if (!r_we) begin
          if (r_owner[1]) w_rdata1 = ram_q;
          else            w_rdata0 = ram_q;
        end
        w_ack0  = r_owner[0];
        w_ack1  = r_owner[1];
        w_state = S_DONE;
      end
      S_DONE: begin
        w_owner = 2'b00;
        w_state = S_IDLE;
      end
      default: begin
        w_owner = 2'b00;
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_last        <= 1'b1;
      r_we          <= 1'b0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_rdata0      <= '0;
      r_rdata1      <= '0;
      r_ram_address <= '0;
      r_ram_data    <= '0;
      r_ram_wren    <= 1'b0;
      r_owner       <= 2'b00;
    end else begin
      r_state       <= w_state;
      r_last        <= w_last;
      r_we          <= w_we;
      r_ack0        <= w_ack0;
      r_ack1        <= w_ack1;
      r_rdata0      <= w_rdata0;
      r_rdata1      <= w_rdata1;
      r_ram_address <= w_ram_address;
      r_ram_data    <= w_ram_data;
      r_ram_wren    <= w_ram_wren;
      r_owner       <= w_owner;
    end
  end

  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;
  assign ram_address = r_ram_address;
  assign ram_data    = r_ram_data;
  assign ram_wren    = r_ram_wren;
  assign owner       = r_owner;
  assign dbg_state   = r_state;

endmodule
